// File: rtl/stack_pkg.sv
// Shared defaults and command-priority encoding for the parameterised stack.
package stack_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 32;

  typedef enum logic [2:0] {
    CLR  = 3'd0,
    REPL = 3'd1,
    POP  = 3'd2,
    PUSH = 3'd3,
    PEEK = 3'd4,
    IDLE = 3'd5
  } cmd_e;

  // Priority: clear > push&pop > pop > push > tos.
  function automatic cmd_e decode_cmd(input logic clr, input logic psh,
                                      input logic pp, input logic pk);
    if (clr)            return CLR;
    else if (psh && pp) return REPL;
    else if (pp)        return POP;
    else if (psh)       return PUSH;
    else if (pk)        return PEEK;
    else                return IDLE;
  endfunction

endpackage

// File: rtl/stack_mem.sv
// DEPTH x WIDTH storage: one synchronous write port, one asynchronous read port.
// No reset on contents; write takes effect on the rising edge.
module stack_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/param_stack.sv
// LIFO stack with prioritised clear/replace/pop/push/peek; reads return one cycle later.
// No backpressure: push when full and read when empty are dropped with an error pulse.
module param_stack
  import stack_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                       clk,
  input  logic                       rstN,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       tos,
  input  logic                       clear,
  input  logic [WIDTH-1:0]           dataIn,
  output logic [WIDTH-1:0]           resStk,
  output logic                       resValid,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] ONE     = CW'(1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  cmd_e             cmd;
  logic [CW-1:0]    cnt_nxt;
  logic [WIDTH-1:0] res_nxt;
  logic             vld_nxt, ovf_nxt, unf_nxt;
  logic             wr_req, mem_we;
  logic [AW-1:0]    waddr, top_addr;
  logic [WIDTH-1:0] top_dat;

  assign empty    = (count == '0);
  assign full     = (count == DEPTH_C);
  assign cmd      = decode_cmd(clear, push, pop, tos);
  assign top_addr = AW'(count - ONE);

  // A write issued while reset is low must not land in memory.
  assign mem_we = wr_req && rstN;

  stack_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (waddr),
    .wdata (dataIn),
    .raddr (top_addr),
    .rdata (top_dat)
  );

  always_comb begin
    cnt_nxt = count;
    res_nxt = resStk;
    vld_nxt = 1'b0;
    ovf_nxt = 1'b0;
    unf_nxt = 1'b0;
    wr_req  = 1'b0;
    waddr   = AW'(count);
    unique case (cmd)
      CLR: cnt_nxt = '0;
      REPL: begin
        if (empty) begin
          wr_req  = 1'b1;
          cnt_nxt = count + ONE;
          unf_nxt = 1'b1;
        end else begin
          res_nxt = top_dat;
          vld_nxt = 1'b1;
          wr_req  = 1'b1;
          waddr   = top_addr;
        end
      end
      POP: begin
        if (empty) begin
          unf_nxt = 1'b1;
        end else begin
          res_nxt = top_dat;
          vld_nxt = 1'b1;
          cnt_nxt = count - ONE;
        end
      end
      PUSH: begin
        if (full) begin
          ovf_nxt = 1'b1;
        end else begin
          wr_req  = 1'b1;
          cnt_nxt = count + ONE;
        end
      end
      PEEK: begin
        if (empty) begin
          unf_nxt = 1'b1;
        end else begin
          res_nxt = top_dat;
          vld_nxt = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      count     <= '0;
      resStk    <= '0;
      resValid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      count     <= cnt_nxt;
      resStk    <= res_nxt;
      resValid  <= vld_nxt;
      overflow  <= ovf_nxt;
      underflow <= unf_nxt;
    end
  end

endmodule

// File: doc/param_stack.md
PARAM_STACK -- requirements
Module: param_stack

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, data word width in bits (>=1).
REQ-002 The block SHALL have parameter DEPTH, default 32, number of entries (>=2, power of two not required).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rstN, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port push, input, 1, write dataIn onto the stack.
REQ-006 The block SHALL have port pop, input, 1, read and remove the top entry.
REQ-007 The block SHALL have port tos, input, 1, read the top entry without removing it.
REQ-008 The block SHALL have port clear, input, 1, synchronous empty-the-stack command.
REQ-009 The block SHALL have port dataIn, input, WIDTH, push data.
REQ-010 The block SHALL have port resStk, output, WIDTH, registered read data.
REQ-011 The block SHALL have port resValid, output, 1, resStk updated by a successful read this cycle (one-cycle pulse).
REQ-012 The block SHALL have ports full and empty, output, 1 each, combinational decodes of count.
REQ-013 The block SHALL have port count, output, $clog2(DEPTH+1), number of stored entries.
REQ-014 The block SHALL have ports overflow and underflow, output, 1 each, registered one-cycle error pulses.

Function
REQ-015 count SHALL hold the index of the next free slot; top entry is stk[count-1]; empty = (count==0); full = (count==DEPTH).
REQ-016 Command priority per cycle SHALL be: clear > push&pop > pop > push > tos; lower commands are ignored.
REQ-017 clear SHALL set count to 0, drive resValid 0, and leave resStk and the memory unchanged.
REQ-018 pop when not empty SHALL load resStk with stk[count-1], pulse resValid, and decrement count; read latency is one cycle.
REQ-019 pop when empty SHALL hold resStk and count, drive resValid 0, and pulse underflow.
REQ-020 push when not full SHALL write dataIn to stk[count] and increment count; resValid 0.
REQ-021 push when full SHALL leave memory and count unchanged and pulse overflow.
REQ-022 push&pop when not empty SHALL load resStk with old stk[count-1], write dataIn to stk[count-1], pulse resValid, and keep count (replace-top).
REQ-023 push&pop when empty SHALL behave as a plain push plus an underflow pulse, with resValid 0.
REQ-024 tos when not empty SHALL load resStk with stk[count-1] and pulse resValid, count unchanged; tos when empty SHALL pulse underflow only.
REQ-025 overflow, underflow and resValid SHALL be 0 in every cycle not listed above; with no command asserted all state holds.
REQ-026 count arithmetic SHALL never wrap: no sequence of commands drives count below 0 or above DEPTH.

Reset
REQ-027 rstN low SHALL immediately force count=0, resStk=0, resValid=0, overflow=0, underflow=0, independent of clk.
REQ-028 Memory contents SHALL NOT be reset; an operation in flight when rstN asserts SHALL be discarded.
REQ-029 The first command SHALL be accepted on the first rising clk edge after rstN deasserts.

Structure
REQ-030 A shared package stack_pkg SHALL hold the default WIDTH/DEPTH constants and the command-priority encoding typedef (CLR, REPL, POP, PUSH, PEEK, IDLE).
REQ-031 Storage SHALL be a sub-module stack_mem (DEPTH x WIDTH, one write port, one asynchronous read port addressed by count-1); control and flags stay in param_stack.

Verification
REQ-032 Reset, push 0x11,0x22,0x33, then pop x3 -> resStk 0x33,0x22,0x11 each with resValid one cycle after pop; count 3->0; empty=1.
REQ-033 DEPTH=4: push 5 words -> full=1 after 4th; 5th push pulses overflow, count stays 4; pop returns 4th word.
REQ-034 Empty stack: pop -> underflow pulse, resValid 0, resStk holds 0; tos -> underflow pulse only.
REQ-035 Stack holds 0xAA,0xBB: push&pop with dataIn 0xCC -> resStk 0xBB, count 2; next pop -> 0xCC; next pop -> 0xAA.
REQ-036 count 3, assert clear with push -> count 0, no write, no resValid; tos then pulses underflow.
REQ-037 count 2, assert rstN low between edges -> outputs zero immediately; after release count 0 and pop pulses underflow.
